// File: rtl/vga_timing_pkg.sv
// Shared raster timing table and counter widths for the multi-mode VGA/DVI generator.
// Pure constants and helpers; no latency, no flow control.
package vga_timing_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef struct packed {
        logic [11:0] h_act;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] v_act;
        logic [11:0] v_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic        hpol;
        logic        vpol;
    } timing_t;

    // Polarity bit: 1 = positive-going sync pulse.
    localparam timing_t MODE_TABLE [4] = '{
        '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0},
        '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1},
        '{12'd1024, 12'd24,  12'd136, 12'd160, 12'd768, 12'd3,  12'd6, 12'd29, 1'b0, 1'b0},
        '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 1'b1}
    };

    function automatic logic [11:0] h_total(input timing_t t);
        return t.h_act + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic logic [11:0] v_total(input timing_t t);
        return t.v_act + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with per-bit reset value; DEPTH=0 is a plain wire.
// Latency DEPTH enabled cycles; holds every stage while en is low.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode raster counter with per-mode sync polarity, strobes and frame-boundary mode switching.
// Counters/strobes registered (1 cycle); sync/blank add SYNC_DELAY; everything holds while enable_in is low.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 1,
    parameter int SYNC_DELAY   = 0
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    input  logic                enable_in,
    input  logic [1:0]          mode_sel_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                blank_out,
    output logic                line_start_out,
    output logic                frame_start_out,
    output logic [1:0]          mode_out,
    output logic                mode_err_out
);

    localparam logic [1:0]          DEF_IDX     = 2'(DEFAULT_MODE);
    localparam timing_t             DEF_T       = MODE_TABLE[DEF_IDX];
    localparam logic [HCOUNT_W-1:0] H_RST       = HCOUNT_W'(h_total(DEF_T) - 12'd1);
    localparam logic [VCOUNT_W-1:0] V_RST       = VCOUNT_W'(v_total(DEF_T) - 12'd1);
    localparam logic [2:0]          FLAG_RST    = {1'b1, ~DEF_T.vpol, ~DEF_T.hpol};
    localparam logic [2:0]          NUM_MODES_V = 3'(NUM_MODES);
    localparam logic [HCOUNT_W-1:0] H_ONE       = HCOUNT_W'(1);
    localparam logic [VCOUNT_W-1:0] V_ONE       = VCOUNT_W'(1);

    logic [1:0]          mode_q, mode_nxt;
    logic [HCOUNT_W-1:0] hcount_q, hc_nxt;
    logic [VCOUNT_W-1:0] vcount_q, vc_nxt;
    logic                hsync_q, vsync_q, blank_q;
    logic                line_start_q, frame_start_q, mode_err_q, err_nxt;
    logic                hs_act, vs_act, blank_nxt;
    timing_t             cur_t, nxt_t;
    logic [11:0]         hc12, vc12, hs_start, vs_start;
    logic [2:0]          dly_q;

    // Flags are computed for the pixel about to be presented, using the timing
    // that will govern it, so a mode switch takes effect exactly at (0,0).
    always_comb begin
        cur_t    = MODE_TABLE[mode_q];
        mode_nxt = mode_q;
        err_nxt  = mode_err_q;
        hc_nxt   = hcount_q + H_ONE;
        vc_nxt   = vcount_q;
        if ({1'b0, hcount_q} == h_total(cur_t) - 12'd1) begin
            hc_nxt = '0;
            if ({2'b0, vcount_q} == v_total(cur_t) - 12'd1) begin
                vc_nxt = '0;
                if ({1'b0, mode_sel_in} < NUM_MODES_V) begin
                    mode_nxt = mode_sel_in;
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                vc_nxt = vcount_q + V_ONE;
            end
        end
        nxt_t     = MODE_TABLE[mode_nxt];
        hc12      = {1'b0, hc_nxt};
        vc12      = {2'b0, vc_nxt};
        hs_start  = nxt_t.h_act + nxt_t.h_fp;
        vs_start  = nxt_t.v_act + nxt_t.v_fp;
        hs_act    = (hc12 >= hs_start) && (hc12 < hs_start + nxt_t.h_sync);
        vs_act    = (vc12 >= vs_start) && (vc12 < vs_start + nxt_t.v_sync);
        blank_nxt = (hc12 >= nxt_t.h_act) || (vc12 >= nxt_t.v_act);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q                       <= DEF_IDX;
            hcount_q                     <= H_RST;
            vcount_q                     <= V_RST;
            {blank_q, vsync_q, hsync_q}  <= FLAG_RST;
            line_start_q                 <= 1'b0;
            frame_start_q                <= 1'b0;
            mode_err_q                   <= 1'b0;
        end else if (enable_in) begin
            mode_q        <= mode_nxt;
            hcount_q      <= hc_nxt;
            vcount_q      <= vc_nxt;
            hsync_q       <= hs_act ? nxt_t.hpol : ~nxt_t.hpol;
            vsync_q       <= vs_act ? nxt_t.vpol : ~nxt_t.vpol;
            blank_q       <= blank_nxt;
            line_start_q  <= (hc_nxt == '0);
            frame_start_q <= (hc_nxt == '0) && (vc_nxt == '0);
            mode_err_q    <= err_nxt;
        end
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (FLAG_RST)
    ) u_sync_dly (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .en    (enable_in),
        .d     ({blank_q, vsync_q, hsync_q}),
        .q     (dly_q)
    );

    assign {blank_out, vsync_out, hsync_out} = dly_q;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign line_start_out  = line_start_q;
    assign frame_start_out = frame_start_q;
    assign mode_out        = mode_q;
    assign mode_err_out    = mode_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven in lockstep against a pixel-position model.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] msel = 2'd1;

    always #5 clk = ~clk;

    logic [10:0] hc [3];
    logic [9:0]  vc [3];
    logic        hs [3], vs [3], bl [3], ls [3], fs [3], er [3];
    logic [1:0]  md [3];
    logic [28:0] obs [3];

    // inst 0: 4 modes, no delay; inst 1: 4 modes, delay 3; inst 2: 2 modes, no delay
    vga_timing_gen #(.NUM_MODES(4), .DEFAULT_MODE(1), .SYNC_DELAY(0)) dut_a (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_sel_in(msel),
        .hcount_out(hc[0]), .vcount_out(vc[0]), .hsync_out(hs[0]), .vsync_out(vs[0]),
        .blank_out(bl[0]), .line_start_out(ls[0]), .frame_start_out(fs[0]),
        .mode_out(md[0]), .mode_err_out(er[0]));
    vga_timing_gen #(.NUM_MODES(4), .DEFAULT_MODE(1), .SYNC_DELAY(3)) dut_b (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_sel_in(msel),
        .hcount_out(hc[1]), .vcount_out(vc[1]), .hsync_out(hs[1]), .vsync_out(vs[1]),
        .blank_out(bl[1]), .line_start_out(ls[1]), .frame_start_out(fs[1]),
        .mode_out(md[1]), .mode_err_out(er[1]));
    vga_timing_gen #(.NUM_MODES(2), .DEFAULT_MODE(1), .SYNC_DELAY(0)) dut_c (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_sel_in(msel),
        .hcount_out(hc[2]), .vcount_out(vc[2]), .hsync_out(hs[2]), .vsync_out(vs[2]),
        .blank_out(bl[2]), .line_start_out(ls[2]), .frame_start_out(fs[2]),
        .mode_out(md[2]), .mode_err_out(er[2]));

    assign obs[0] = {hc[0], vc[0], hs[0], vs[0], bl[0], ls[0], fs[0], md[0], er[0]};
    assign obs[1] = {hc[1], vc[1], hs[1], vs[1], bl[1], ls[1], fs[1], md[1], er[1]};
    assign obs[2] = {hc[2], vc[2], hs[2], vs[2], bl[2], ls[2], fs[2], md[2], er[2]};

    // Mode 1 reset state: (1055,627), syncs low, blank high, no strobes, mode 1, no error.
    localparam logic [28:0] RST_VEC = {11'd1055, 10'd627, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};

    int   HA [4] = '{640, 800, 1024, 1280};
    int   HF [4] = '{16, 40, 24, 110};
    int   HS [4] = '{96, 128, 136, 40};
    int   HB [4] = '{48, 88, 160, 220};
    int   VA [4] = '{480, 600, 768, 720};
    int   VF [4] = '{10, 1, 3, 5};
    int   VS [4] = '{2, 4, 6, 5};
    int   VB [4] = '{33, 23, 29, 20};
    logic HP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic VP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   NM [3] = '{4, 4, 2};
    int   DL [3] = '{0, 3, 0};

    int         m_h [3], m_v [3], m_md [3];
    logic       m_err [3];
    logic [2:0] hist [3][16];
    int         checks = 0;
    int         failures = 0;

    function automatic int htot(int m); return HA[m] + HF[m] + HS[m] + HB[m]; endfunction
    function automatic int vtot(int m); return VA[m] + VF[m] + VS[m] + VB[m]; endfunction

    // {blank, vsync level, hsync level} for pixel (h,v) in mode m
    function automatic logic [2:0] raw_flags(int m, int h, int v);
        logic hsa, vsa, b;
        hsa = (h >= HA[m] + HF[m]) && (h < HA[m] + HF[m] + HS[m]);
        vsa = (v >= VA[m] + VF[m]) && (v < VA[m] + VF[m] + VS[m]);
        b   = (h >= HA[m]) || (v >= VA[m]);
        return {b, vsa ? VP[m] : ~VP[m], hsa ? HP[m] : ~HP[m]};
    endfunction

    function automatic logic [28:0] exp_vec(int i);
        logic [2:0] f;
        f = hist[i][DL[i]];
        return {11'(m_h[i]), 10'(m_v[i]), f[0], f[1], f[2], (m_h[i] == 0),
                (m_h[i] == 0 && m_v[i] == 0), 2'(m_md[i]), m_err[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_md[i] = 1; m_h[i] = htot(1) - 1; m_v[i] = vtot(1) - 1; m_err[i] = 1'b0;
            for (int k = 0; k < 16; k++) hist[i][k] = raw_flags(1, m_h[i], m_v[i]);
        end
    endtask

    task automatic model_step();
        int nh;
        for (int i = 0; i < 3; i++) begin
            nh = (m_h[i] + 1) % htot(m_md[i]);
            if (nh == 0) begin
                m_v[i] = (m_v[i] + 1) % vtot(m_md[i]);
                if (m_v[i] == 0) begin
                    if (int'(msel) < NM[i]) m_md[i] = int'(msel);
                    else m_err[i] = 1'b1;
                end
            end
            m_h[i] = nh;
            for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = raw_flags(m_md[i], m_h[i], m_v[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && en) model_step();
        #1;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        msel  = sel;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== RST_VEC) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs[i], RST_VEC);
            end
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                failures++;
                $display("FAIL reset_model inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_free_run();
        int first_hs, hs_cnt, bl_rise;
        logic prev_bl;
        first_hs = -1; hs_cnt = 0; bl_rise = -1; prev_bl = 1'b0;
        do_reset(2'd1);
        tick();
        checks++;
        if ({hc[0], vc[0], fs[0], ls[0]} !== {11'd0, 10'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL first_pixel got h=%0d v=%0d fs=%b ls=%b exp 0 0 1 1", hc[0], vc[0], fs[0], ls[0]);
        end
        for (int n = 0; n < 2 * 1056 + 8; n++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL free_run inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
            if (vc[0] == 10'd0) begin
                if (hs[0] && first_hs < 0) first_hs = int'(hc[0]);
                if (hs[0]) hs_cnt++;
                if (bl[0] && !prev_bl && bl_rise < 0) bl_rise = int'(hc[0]);
            end
            prev_bl = bl[0];
            tick();
        end
        checks++;
        if (first_hs != 840) begin failures++; $display("FAIL m1_hsync_start got=%0d exp=840", first_hs); end
        checks++;
        if (hs_cnt != 128) begin failures++; $display("FAIL m1_hsync_width got=%0d exp=128", hs_cnt); end
        checks++;
        if (bl_rise != 800) begin failures++; $display("FAIL m1_blank_rise got=%0d exp=800", bl_rise); end
    endtask

    task automatic test_mode_switch();
        int first_lo, lo_cnt, ls_n;
        first_lo = -1; lo_cnt = 0; ls_n = -1;
        do_reset(2'd2);
        tick();
        checks++;
        if ({md[0], md[1], md[2], er[0], er[1], er[2]} !== {2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL switch_to_2 got modes=%0d,%0d,%0d errs=%b%b%b exp 2,2,1 001",
                     md[0], md[1], md[2], er[0], er[1], er[2]);
        end
        for (int n = 0; n < 1344 + 20; n++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL mode2_run inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
            if (vc[0] == 10'd0) begin
                if (!hs[0] && first_lo < 0) first_lo = int'(hc[0]);
                if (!hs[0]) lo_cnt++;
            end
            if (n > 0 && ls[0] && ls_n < 0) ls_n = n;
            msel = 2'($urandom_range(0, 3));
            tick();
        end
        checks++;
        if (first_lo != 1048) begin failures++; $display("FAIL m2_hsync_start got=%0d exp=1048", first_lo); end
        checks++;
        if (lo_cnt != 136) begin failures++; $display("FAIL m2_hsync_width got=%0d exp=136", lo_cnt); end
        checks++;
        if (ls_n != 1344) begin failures++; $display("FAIL m2_line_period got=%0d exp=1344", ls_n); end
        checks++;
        if (md[0] !== 2'd2) begin failures++; $display("FAIL m2_mode_held got=%0d exp=2", md[0]); end
    endtask

    task automatic test_sync_delay();
        int t656, tfall, t640, trise;
        logic prev_hs, prev_bl;
        t656 = -1; tfall = -1; t640 = -1; trise = -1; prev_hs = 1'b0; prev_bl = 1'b1;
        do_reset(2'd0);
        tick();
        checks++;
        if ({hs[0], hs[1], ls[1], bl[1]} !== 4'b1011) begin
            failures++;
            $display("FAIL delay_first got hs_a=%b hs_b=%b ls_b=%b bl_b=%b exp 1 0 1 1", hs[0], hs[1], ls[1], bl[1]);
        end
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL delay_run inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
            if (hc[1] == 11'd656 && t656 < 0) t656 = n;
            if (hc[1] == 11'd640 && t640 < 0) t640 = n;
            if (t656 >= 0 && tfall < 0 && prev_hs && !hs[1]) tfall = n;
            if (t640 >= 0 && trise < 0 && !prev_bl && bl[1]) trise = n;
            prev_hs = hs[1];
            prev_bl = bl[1];
            tick();
        end
        checks++;
        if (t656 < 0 || tfall - t656 != 3) begin
            failures++; $display("FAIL delay_hsync got=%0d exp=3", tfall - t656);
        end
        checks++;
        if (t640 < 0 || trise - t640 != 3) begin
            failures++; $display("FAIL delay_blank got=%0d exp=3", trise - t640);
        end
    endtask

    task automatic test_enable_freeze();
        int guard;
        guard = 0;
        while (m_h[0] != 500 && guard < 2000) begin
            tick();
            guard++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL pre_freeze inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (hc[0] !== 11'd500) begin failures++; $display("FAIL freeze_start got=%0d exp=500", hc[0]); end
        en = 1'b0;
        for (int n = 0; n < 50; n++) begin
            msel = 2'($urandom_range(0, 3));
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL frozen inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (hc[0] !== 11'd500) begin failures++; $display("FAIL freeze_hold got=%0d exp=500", hc[0]); end
        en = 1'b1;
        tick();
        checks++;
        if (hc[0] !== 11'd501) begin failures++; $display("FAIL freeze_resume got=%0d exp=501", hc[0]); end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        do_reset(2'd3);
        tick();
        while (m_h[0] != 700 && guard < 2000) begin
            tick();
            guard++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL mode3_run inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if ({md[0], hc[0]} !== {2'd3, 11'd700}) begin
            failures++; $display("FAIL mode3_reach got mode=%0d h=%0d exp 3 700", md[0], hc[0]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== RST_VEC) begin
                failures++;
                $display("FAIL async_reset inst=%0d got=%h exp=%h", i, obs[i], RST_VEC);
            end
        end
        tick();
        tick();
        checks++;
        if (obs[1] !== RST_VEC) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", obs[1], RST_VEC);
        end
        msel  = 2'd1;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({hc[0], vc[0], fs[0], md[0]} !== {11'd0, 10'd0, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL post_release got h=%0d v=%0d fs=%b mode=%0d exp 0 0 1 1", hc[0], vc[0], fs[0], md[0]);
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 6; r++) begin
            do_reset(2'($urandom_range(0, 3)));
            len = $urandom_range(300, 1500);
            for (int n = 0; n < len; n++) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== exp_vec(i)) begin
                        failures++;
                        $display("FAIL random r=%0d inst=%0d got=%h exp=%h", r, i, obs[i], exp_vec(i));
                    end
                end
                en   = ($urandom_range(0, 9) != 0);
                msel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 399) == 0) begin
                    #2 rst_n = 1'b0;
                    model_reset();
                    #1;
                    tick();
                    rst_n = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_mode_switch();
        test_sync_delay();
        test_enable_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
